// File: rtl/conv_window_buffer_pkg.sv
// Shared types and constants for the 3x3 convolution window buffer.
package conv_pkg;

    typedef logic [7:0] pixel_t;
    typedef logic [7:0] coef_t;

    localparam int KERNEL_TAPS = 9;
    localparam int COEF_ADDR_W = 4;

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel stream, coefficient write port and window/coefficient outputs of conv_window_buffer.
// frame_done exists only when CONV_WIN_FRAME_DONE_EN is defined.
interface conv_window_buffer_if;
    import conv_pkg::*;

    pixel_t                 pix_in;
    logic                   pix_valid;
    logic                   frame_start;
    logic                   coef_we;
    logic [COEF_ADDR_W-1:0] coef_addr;
    coef_t                  coef_data;

    pixel_t X0, X1, X2, X3, X4, X5, X6, X7, X8;
    coef_t  H0, H1, H2, H3, H4, H5, H6, H7, H8;
    logic   win_valid;
`ifdef CONV_WIN_FRAME_DONE_EN
    logic   frame_done;
`endif

    modport master (
        output pix_in, pix_valid, frame_start, coef_we, coef_addr, coef_data,
        input  X0, X1, X2, X3, X4, X5, X6, X7, X8,
        input  H0, H1, H2, H3, H4, H5, H6, H7, H8,
`ifdef CONV_WIN_FRAME_DONE_EN
        input  frame_done,
`endif
        input  win_valid
    );

    modport slave (
        input  pix_in, pix_valid, frame_start, coef_we, coef_addr, coef_data,
        output X0, X1, X2, X3, X4, X5, X6, X7, X8,
        output H0, H1, H2, H3, H4, H5, H6, H7, H8,
`ifdef CONV_WIN_FRAME_DONE_EN
        output frame_done,
`endif
        output win_valid
    );

endinterface

// File: rtl/conv_window_buffer_line_buffer.sv
// One image row of pixel storage: asynchronous read, synchronous write, no reset.
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);

    pixel_t mem [DEPTH];

    // Contents are never cleared; the window-valid flag masks stale rows.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_buffer.sv
// 3x3 sliding window over a raster pixel stream plus a 9-entry kernel coefficient bank.
// Optional frame_done output enabled by defining CONV_WIN_FRAME_DONE_EN.
module conv_window_buffer
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_window_buffer_if.slave  bus
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] curCol;
    logic [RW-1:0] curRow;
    logic          accept;
    pixel_t        top;
    pixel_t        mid;
    pixel_t        win [KERNEL_TAPS];
    coef_t         h   [KERNEL_TAPS];
    logic          winValid;

    // frame_start overrides the counters so this pixel lands at (0,0).
    assign accept = bus.pix_valid;
    assign curCol = bus.frame_start ? '0 : col;
    assign curRow = bus.frame_start ? '0 : row;

    line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_line0 (
        .clk   (clk),
        .we    (accept & ~rst),
        .addr  (curCol),
        .wdata (bus.pix_in),
        .rdata (mid)
    );

    line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_line1 (
        .clk   (clk),
        .we    (accept & ~rst),
        .addr  (curCol),
        .wdata (mid),
        .rdata (top)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (curCol == LAST_COL) begin
                col <= '0;
                row <= (curRow == LAST_ROW) ? '0 : curRow + RW'(1);
            end else begin
                col <= curCol + CW'(1);
                row <= curRow;
            end
        end
    end

    // Window shifts left one column per accepted pixel; right column is (top, mid, new pixel).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                win[i] <= '0;
            end
            winValid <= 1'b0;
        end else begin
            winValid <= accept && (curRow >= RW'(2)) && (curCol >= CW'(2));
            if (accept) begin
                win[0] <= win[1];
                win[1] <= win[2];
                win[2] <= top;
                win[3] <= win[4];
                win[4] <= win[5];
                win[5] <= mid;
                win[6] <= win[7];
                win[7] <= win[8];
                win[8] <= bus.pix_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                h[i] <= '0;
            end
        end else if (bus.coef_we) begin
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                if (bus.coef_addr == COEF_ADDR_W'(i)) begin
                    h[i] <= bus.coef_data;
                end
            end
        end
    end

`ifdef CONV_WIN_FRAME_DONE_EN
    logic frameDone;

    always_ff @(posedge clk) begin
        if (rst) begin
            frameDone <= 1'b0;
        end else begin
            frameDone <= accept && (curRow == LAST_ROW) && (curCol == LAST_COL);
        end
    end

    assign bus.frame_done = frameDone;
`endif

    assign bus.X0 = win[0];
    assign bus.X1 = win[1];
    assign bus.X2 = win[2];
    assign bus.X3 = win[3];
    assign bus.X4 = win[4];
    assign bus.X5 = win[5];
    assign bus.X6 = win[6];
    assign bus.X7 = win[7];
    assign bus.X8 = win[8];

    assign bus.H0 = h[0];
    assign bus.H1 = h[1];
    assign bus.H2 = h[2];
    assign bus.H3 = h[3];
    assign bus.H4 = h[4];
    assign bus.H5 = h[5];
    assign bus.H6 = h[6];
    assign bus.H7 = h[7];
    assign bus.H8 = h[8];

    assign bus.win_valid = winValid;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Self-checking bench for conv_window_buffer (4x4 image): directed scenarios plus random traffic
// against an image-array reference model.
module tb_conv_window_buffer;

    localparam int W = 4;
    localparam int H = 4;

    logic clk;
    logic rst;

    conv_window_buffer_if cif ();

    conv_window_buffer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (cif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] obsX [9];
    logic [7:0] obsH [9];
    assign obsX[0] = cif.X0;  assign obsX[1] = cif.X1;  assign obsX[2] = cif.X2;
    assign obsX[3] = cif.X3;  assign obsX[4] = cif.X4;  assign obsX[5] = cif.X5;
    assign obsX[6] = cif.X6;  assign obsX[7] = cif.X7;  assign obsX[8] = cif.X8;
    assign obsH[0] = cif.H0;  assign obsH[1] = cif.H1;  assign obsH[2] = cif.H2;
    assign obsH[3] = cif.H3;  assign obsH[4] = cif.H4;  assign obsH[5] = cif.H5;
    assign obsH[6] = cif.H6;  assign obsH[7] = cif.H7;  assign obsH[8] = cif.H8;

    int checkCount = 0;
    int passCount  = 0;
    int winCount   = 0;

    // Reference model: current frame stored as a 2-D image, position tracked as (row, col).
    logic [7:0] img [H][W];
    int         mr, mc;
    logic [7:0] expX [9];
    logic [7:0] expH [9];
    logic       xKnown;
    logic       expValid;
    logic       expDone;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] p, input logic fs,
                                 input logic we, input logic [3:0] a, input logic [7:0] d,
                                 input logic r);
        rst             = r;
        cif.pix_valid   = v;
        cif.pix_in      = p;
        cif.frame_start = fs;
        cif.coef_we     = we;
        cif.coef_addr   = a;
        cif.coef_data   = d;
        @(posedge clk);
        if (r) begin
            mr = 0;
            mc = 0;
            expValid = 1'b0;
            expDone  = 1'b0;
            xKnown   = 1'b1;
            for (int i = 0; i < 9; i++) begin
                expX[i] = 8'h00;
                expH[i] = 8'h00;
            end
        end else begin
            if (we && a < 4'd9) expH[a] = d;
            expValid = 1'b0;
            expDone  = 1'b0;
            if (v) begin
                if (fs) begin
                    mr = 0;
                    mc = 0;
                end
                img[mr][mc] = p;
                if (mr >= 2 && mc >= 2) begin
                    expValid = 1'b1;
                    xKnown   = 1'b1;
                    for (int i = 0; i < 9; i++) expX[i] = img[mr - 2 + i / 3][mc - 2 + i % 3];
                end else begin
                    xKnown = 1'b0;
                end
                expDone = (mr == H - 1) && (mc == W - 1);
                mc++;
                if (mc == W) begin
                    mc = 0;
                    mr++;
                    if (mr == H) mr = 0;
                end
            end
        end
        #1;
        checkOutput("win_valid", {31'd0, cif.win_valid}, {31'd0, expValid});
`ifdef CONV_WIN_FRAME_DONE_EN
        checkOutput("frame_done", {31'd0, cif.frame_done}, {31'd0, expDone});
`endif
        if (xKnown) begin
            for (int i = 0; i < 9; i++) checkOutput($sformatf("X%0d", i), {24'd0, obsX[i]}, {24'd0, expX[i]});
        end
        for (int i = 0; i < 9; i++) checkOutput($sformatf("H%0d", i), {24'd0, obsH[i]}, {24'd0, expH[i]});
        if (cif.win_valid) winCount++;
    endtask

    task automatic pushPixel(input logic [7:0] p, input logic fs);
        applyStimulus(1'b1, p, fs, 1'b0, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic resetCycle();
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1, 4'd3, 8'h55, 1'b1);
    endtask

    task automatic checkWindow(input string tag, input logic [7:0] e [9]);
        for (int i = 0; i < 9; i++) checkOutput($sformatf("%s_X%0d", tag, i), {24'd0, obsX[i]}, {24'd0, e[i]});
    endtask

    initial begin
        int firstAt;
        int n;
        logic [7:0] rp;
        logic [3:0] ra;

        resetCycle();

        // Scenarios 1 and 2: full frame.
        winCount = 0;
        for (int p = 1; p <= 16; p++) begin
            pushPixel(8'(p), p == 1);
            if (p == 11) begin
                checkOutput("sc1_valid", {31'd0, cif.win_valid}, 32'd1);
                checkWindow("sc1", '{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
            end
        end
        checkOutput("sc2_last_valid", {31'd0, cif.win_valid}, 32'd1);
        checkWindow("sc2", '{8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16});
`ifdef CONV_WIN_FRAME_DONE_EN
        checkOutput("sc2_done", {31'd0, cif.frame_done}, 32'd1);
`endif
        checkOutput("sc2_count", winCount, 32'd4);

        // Scenario 3: idle gap between pixels 11 and 12.
        for (int p = 1; p <= 11; p++) pushPixel(8'(p), p == 1);
        for (int g = 0; g < 3; g++) idleCycle();
        pushPixel(8'd12, 1'b0);
        checkWindow("sc3", '{8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12});
        for (int p = 13; p <= 16; p++) pushPixel(8'(p), 1'b0);

        // Scenario 4: reset mid-frame, then a fresh frame without frame_start.
        for (int p = 1; p <= 10; p++) pushPixel(8'(p + 100), p == 1);
        resetCycle();
        winCount = 0;
        for (int p = 1; p <= 16; p++) begin
            pushPixel(8'(p), 1'b0);
            if (p == 11) checkWindow("sc4", '{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
        end
        checkOutput("sc4_count", winCount, 32'd4);

        // Scenario 5: coefficient writes, then an out-of-range address.
        for (int a = 0; a < 9; a++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 4'(a), 8'(8'h10 + a), 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, 4'd9, 8'hFF, 1'b0);
        checkOutput("sc5_H0", {24'd0, cif.H0}, 32'h10);
        checkOutput("sc5_H8", {24'd0, cif.H8}, 32'h18);

        // Scenario 6: frame_start at pixel 7 realigns the counters.
        for (int p = 1; p <= 6; p++) pushPixel(8'(p), p == 1);
        firstAt = 0;
        n = 0;
        for (int p = 7; p <= 30; p++) begin
            pushPixel(8'(p), p == 7);
            n++;
            if (cif.win_valid && firstAt == 0) firstAt = n;
        end
        checkOutput("sc6_first_window", firstAt, 32'd11);

        // Random traffic with concurrent coefficient writes, frame_start and resets.
        for (int k = 0; k < 800; k++) begin
            rp = 8'($urandom);
            ra = 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 3) != 0, rp, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 3) == 0, ra, 8'($urandom),
                          $urandom_range(0, 79) == 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/conv_window_buffer.md
CONV_WINDOW_BUFFER -- requirements
Module: conv_window_buffer

Interface
REQ-001 The block SHALL have parameter IMG_W, default 32, meaning image width in pixels; legal range 3 to 1024.
REQ-002 The block SHALL have parameter IMG_H, default 32, meaning image height in pixels; legal range 3 to 1024.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port pix_in, input, 8 bits: raster-order pixel.
REQ-006 The block SHALL have port pix_valid, input, 1 bit: pix_in is accepted this cycle.
REQ-007 The block SHALL have port frame_start, input, 1 bit: qualified by pix_valid; marks the pixel as row 0, column 0.
REQ-008 The block SHALL have ports coef_we (1 bit), coef_addr (4 bits) and coef_data (8 bits), all inputs, forming the kernel-coefficient write port.
REQ-009 The block SHALL have outputs X0 to X8, 8 bits each: 3x3 window in row-major order; X0 is top-left, X4 is centre, X8 is bottom-right (newest pixel).
REQ-010 The block SHALL have outputs H0 to H8, 8 bits each: held kernel coefficients, wired directly to the downstream convolution stage.
REQ-011 The block SHALL have output win_valid, 1 bit: X0 to X8 form a complete in-image window this cycle.

Function
REQ-012 Column and row counters SHALL be maintained as follows:
- On each accepted pixel, col increments.
- At IMG_W-1, col wraps to 0 and row increments.
- At the last pixel (col IMG_W-1, row IMG_H-1), both counters wrap to 0.
REQ-013 An accepted pixel with frame_start=1 SHALL be treated as (row 0, col 0) regardless of counter state; counters then continue from (0, 1).
REQ-014 Two line buffers, each IMG_W x 8 bits and addressed by col, SHALL be updated on acceptance as follows:
- top = line1[col]; mid = line0[col].
- line1[col] is written with line0[col].
- line0[col] is written with pix_in.
REQ-015 On acceptance the window SHALL shift one column left, and the new right column SHALL be (X2, X5, X8) = (top, mid, pix_in).
REQ-016 win_valid SHALL assert in the cycle after accepting a pixel at row>=2 and col>=2, and SHALL deassert otherwise, including after idle (pix_valid=0) cycles; latency is exactly 1 cycle.
REQ-017 X0 to X8 SHALL hold their value while pix_valid=0.
REQ-018 Windows straddling a line wrap (col<2) SHALL never be flagged valid; each frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) valid windows.
REQ-019 coef_we=1 with coef_addr 0 to 8 SHALL write coef_data to H[coef_addr] at the next edge; addresses 9 to 15 SHALL be ignored.
REQ-020 Coefficient writes and pixel acceptance in the same cycle SHALL be independent and both take effect.

Reset
REQ-021 While rst=1 the following SHALL be cleared at the edge: col, row, X0 to X8, H0 to H8, win_valid (all to 0), and frame_done (to 0) when present.
REQ-022 rst SHALL take priority over pix_valid and coef_we in the same cycle.
REQ-023 Line-buffer contents SHALL NOT be reset; stale data is masked by REQ-016.
REQ-024 Reset asserted mid-frame SHALL restart the frame: the next accepted pixel is (0,0).

Configuration
REQ-025 With CONV_WIN_FRAME_DONE_EN defined, the block SHALL have output frame_done (1 bit), pulsing high for one cycle, aligned with win_valid, for the window of the last pixel of a frame.
REQ-026 Without CONV_WIN_FRAME_DONE_EN, the frame_done port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 The shared package conv_pkg SHALL hold the pixel_t (8-bit) and coef_t (8-bit) typedefs and the constants KERNEL_TAPS=9 and COEF_ADDR_W=4.
REQ-028 The line buffer SHALL be one sub-module, line_buffer, instantiated twice; the window registers and counters SHALL stay in the top level.

Verification
REQ-029 The bench SHALL cover, with IMG_W=IMG_H=4:
- Scenario 1: frame_start on pixel 1, then pixels 1..16 continuous -> first win_valid one cycle after pixel 11, with X0..X8 = 1,2,3,5,6,7,9,10,11.
- Scenario 2: same frame -> exactly 4 win_valid pulses, the last with X0..X8 = 6,7,8,10,11,12,14,15,16; frame_done high on that pulse when enabled.
- Scenario 3: pix_valid deasserted for 3 cycles between pixels 11 and 12 -> win_valid low during the gap, X held, then window 2,3,4,6,7,8,10,11,12 after pixel 12.
- Scenario 4: rst asserted after pixel 10, then pixels 1..16 -> no stale windows; first window again 1,2,3,5,6,7,9,10,11.
- Scenario 5: coef writes addr 0..8 with data 0x10..0x18, then addr 9 with 0xFF -> H0..H8 = 0x10..0x18, unchanged by the addr-9 write.
- Scenario 6: frame_start asserted mid-frame at pixel 7 -> counters realign, and the next valid window appears after 11 further pixels.
